// File: rtl/inc_seq_checker_pkg.sv
// Shared definitions for the incrementing-sequence link: checker state
// encoding and the default data word width used by the producing stage.
package inc_seq_checker_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2,
    SLIP    = 2'd3
  } chk_state_e;

endpackage

// File: rtl/inc_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over
// increment, and the count sticks at all-ones instead of wrapping.
module inc_seq_checker_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/inc_seq_checker.sv
// Receive-side checker for an incrementing word stream: hunts for alignment,
// confirms LOCK_COUNT good increments, then flags and counts sequence errors.
module inc_seq_checker
  import inc_seq_checker_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int LOCK_COUNT    = 4,
  parameter int LOSS_COUNT    = 3,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic [WIDTH-1:0]         DATA_I,
  input  logic                     VALID_I,
  input  logic                     CLEAR_I,
  output logic                     LOCKED_O,
  output logic                     ERROR_O,
  output logic [ERR_CNT_WIDTH-1:0] ERR_COUNT_O,
  output logic [WIDTH-1:0]         EXPECT_O
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(LOSS_COUNT + 1);

  chk_state_e        state_q, state_d;
  logic [WIDTH-1:0]  expect_q, expect_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              locked_q, locked_d;
  logic              error_q, error_d;

  logic              match;
  logic [RUN_W-1:0]  run_inc;
  logic [MISS_W-1:0] miss_inc;

  assign match    = (DATA_I == expect_q);
  assign run_inc  = run_q + RUN_W'(1);
  assign miss_inc = miss_q + MISS_W'(1);

  // Every valid sample reseeds the expectation, matched or not, so a single
  // corrupted word costs exactly one error once the stream resumes.
  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    run_d    = run_q;
    miss_d   = miss_q;
    locked_d = locked_q;
    error_d  = 1'b0;

    if (VALID_I) begin
      expect_d = DATA_I + WIDTH'(1);
      case (state_q)
        HUNT: begin
          run_d   = '0;
          state_d = CONFIRM;
        end
        CONFIRM: begin
          if (match) begin
            run_d = run_inc;
            if (run_inc == RUN_W'(LOCK_COUNT)) begin
              run_d    = '0;
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            error_d = 1'b1;
            miss_d  = MISS_W'(1);
            if (LOSS_COUNT == 1) begin
              miss_d   = '0;
              state_d  = HUNT;
              locked_d = 1'b0;
            end else begin
              state_d = SLIP;
            end
          end
        end
        SLIP: begin
          if (match) begin
            miss_d  = '0;
            state_d = LOCKED;
          end else begin
            error_d = 1'b1;
            miss_d  = miss_inc;
            if (miss_inc == MISS_W'(LOSS_COUNT)) begin
              miss_d   = '0;
              state_d  = HUNT;
              locked_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= HUNT;
      expect_q <= '0;
      run_q    <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      expect_q <= expect_d;
      run_q    <= run_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      error_q  <= error_d;
    end
  end

  // Fed from the same next-state decision as ERROR_O so the count and the
  // pulse land on the same edge.
  inc_seq_checker_sat_counter #(
    .W (ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk_i   (CLK_I),
    .rst_i   (RST_I),
    .inc_i   (error_d),
    .clr_i   (CLEAR_I),
    .count_o (ERR_COUNT_O)
  );

  assign LOCKED_O = locked_q;
  assign ERROR_O  = error_q;
  assign EXPECT_O = expect_q;

endmodule

// File: doc/inc_seq_checker.md
Name: inc_seq_checker

Overview:
- Receive-side checker for the incrementing byte stream produced by the data-path stage (each word = previous + 1, modulo 2^WIDTH).
- Sits at the consumer end of that link. Hunts for sequence alignment, declares lock, then counts and flags sequence errors.
- Drives status outputs for software and for the test harness.

Parameters:
- WIDTH, 8, data word width in bits.
- LOCK_COUNT, 4, consecutive correct increments after the seed word needed to declare lock (>=1).
- LOSS_COUNT, 3, consecutive mismatches while locked that drop lock (>=1).
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- CLK_I  input  1  Clock; all logic on rising edge.
- RST_I  input  1  Synchronous, active-high reset.
- DATA_I  input  WIDTH  Received data word.
- VALID_I  input  1  DATA_I is a valid sample this cycle.
- CLEAR_I  input  1  Clears ERR_COUNT_O on the next edge.
- LOCKED_O  output  1  High in LOCKED and SLIP states.
- ERROR_O  output  1  One-cycle pulse per mismatching sample while LOCKED/SLIP.
- ERR_COUNT_O  output  ERR_CNT_WIDTH  Saturating count of sequence errors.
- EXPECT_O  output  WIDTH  Next expected data word.

Behaviour:
- Interface: one clock, CLK_I; reset RST_I is synchronous and active-high.
- Reset: state=HUNT. LOCKED_O=0, ERROR_O=0, ERR_COUNT_O=0, EXPECT_O=0, internal run/miss counters=0.
- Reset mid-operation: same values on the next edge, regardless of state.
- Only cycles with VALID_I=1 advance state. With VALID_I=0, all state is held, DATA_I is ignored, and ERROR_O=0.
- match = (DATA_I == EXPECT_O). EXPECT_O updates to DATA_I+1 truncated to WIDTH on every valid sample, whether it matched or not.
- Wrap-around: 0xFF followed by 0x00 (WIDTH=8) is a match.
- Latency: every output is registered. The effect of a sample appears on the outputs in the cycle after it is sampled.
- State HUNT: a valid sample seeds EXPECT_O, sets run=0, and moves to CONFIRM.
- State CONFIRM:
  - match: run+1. When run reaches LOCK_COUNT, go to LOCKED and set LOCKED_O=1.
  - mismatch: reseed, run=0, stay in CONFIRM.
  - ERROR_O is never asserted in HUNT or CONFIRM.
- State LOCKED:
  - match: stay.
  - mismatch: ERROR_O=1, ERR_COUNT_O+1, miss=1. Go to SLIP, or go to HUNT if LOSS_COUNT==1.
- State SLIP:
  - match: miss=0, return to LOCKED.
  - mismatch: ERROR_O=1, ERR_COUNT_O+1, miss+1. When miss reaches LOSS_COUNT, go to HUNT and set LOCKED_O=0 on the same edge.
- ERR_COUNT_O saturates at all-ones and never wraps.
- CLEAR_I sets ERR_COUNT_O to 0 on the next edge. If CLEAR_I coincides with an error increment, clear wins (result 0), and ERROR_O still pulses.
- CLEAR_I does not affect state, lock, or EXPECT_O.

Decomposition:
- Shared package/include holds:
  - State encoding constants: HUNT=2'd0, CONFIRM=2'd1, LOCKED=2'd2, SLIP=2'd3.
  - The default WIDTH constant shared with the producing stage.
- One natural sub-module: sat_counter (parameterised width; inc, clr, clr-priority, saturate). Used for ERR_COUNT_O.

Test Plan:
- Lock: (WIDTH=8, LOCK_COUNT=4, LOSS_COUNT=3) after reset, feed 0x10..0x14 on consecutive valid cycles -> LOCKED_O rises the cycle after 0x14; ERR_COUNT_O=0; EXPECT_O=0x15.
- Wrap: while locked, feed 0xFE,0xFF,0x00,0x01 -> no ERROR_O; EXPECT_O=0x02.
- Glitch: locked expecting 0x21, feed 0x21,0x55,0x56 -> exactly one ERROR_O pulse; ERR_COUNT_O=1; back to LOCKED after 0x56; LOCKED_O stays 1.
- Loss: locked expecting 0x30, feed 0x00,0x00,0x00 -> three ERROR_O pulses; ERR_COUNT_O=3; LOCKED_O=0 the cycle after the third sample; state HUNT.
- Gaps and clear:
  - VALID_I=0 for 5 cycles with DATA_I=0xAA mid-stream -> no state, EXPECT_O or ERROR_O change.
  - CLEAR_I asserted on the same cycle as a mismatch -> ERR_COUNT_O=0 and ERROR_O pulses.
- Reset: RST_I=1 for 1 cycle while LOCKED with ERR_COUNT_O=5 -> all outputs 0 the next cycle; re-lock with 0x40..0x44 works.
